// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter
//   Weighted round-robin arbiter for a burst-oriented shared resource.
//   A grant is held for a whole burst of req_len beats, counted on beat_done.
//   A client may win up to `weight` consecutive bursts before priority
//   rotates past it. A client that drops req mid-burst aborts its burst.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   req         level request per client
//   req_len     beats per burst, client i at [i*LEN_W +: LEN_W] (0 means 1)
//   weight      consecutive-burst allowance per client (0 means 1), quasi-static
//   beat_done   resource finished one beat of the current burst
//   grant       registered one-hot grant, or zero
//   grant_id    index of the granted client, valid while busy
//   busy        a burst is in progress
//   burst_last  combinational, beat_done is completing the final beat
module wrr_burst_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int LEN_W       = 4,
    parameter int WEIGHT_W    = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CLIENTS-1:0]          req,
    input  logic [NUM_CLIENTS*LEN_W-1:0]    req_len,
    input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weight,
    input  logic                            beat_done,
    output logic [NUM_CLIENTS-1:0]          grant,
    output logic [$clog2(NUM_CLIENTS)-1:0]  grant_id,
    output logic                            busy,
    output logic                            burst_last
);

    localparam int ID_W = $clog2(NUM_CLIENTS);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                   state_reg,    state_next;
    logic [NUM_CLIENTS-1:0]   grant_reg,    grant_next;
    logic [ID_W-1:0]          grant_id_reg, grant_id_next;
    logic [LEN_W-1:0]         beat_cnt_reg, beat_cnt_next;
    logic [ID_W-1:0]          rr_ptr_reg,   rr_ptr_next;

    // Credits are kept as "bursts already used" so that reset and reload
    // are a plain clear; remaining credit is weight_eff - used.
    logic [WEIGHT_W-1:0]      used_cnt   [NUM_CLIENTS];
    logic [LEN_W-1:0]         len_eff    [NUM_CLIENTS];
    logic [WEIGHT_W-1:0]      weight_eff [NUM_CLIENTS];

    logic                     credit_inc;
    logic                     credit_clr;

    // Zero length / zero weight are promoted to one.
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_eff
            assign len_eff[gi]    = (req_len[gi*LEN_W +: LEN_W] == '0)
                                    ? LEN_W'(1) : req_len[gi*LEN_W +: LEN_W];
            assign weight_eff[gi] = (weight[gi*WEIGHT_W +: WEIGHT_W] == '0)
                                    ? WEIGHT_W'(1) : weight[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    // First requester at or above ptr, wrapping modulo NUM_CLIENTS.
    // Returns {found, index}.
    function automatic logic [ID_W:0] pick_from(input logic [NUM_CLIENTS-1:0] r,
                                                input logic [ID_W-1:0]        ptr);
        logic            found;
        logic [ID_W-1:0] sel;
        int              idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CLIENTS) begin
                idx = idx - NUM_CLIENTS;
            end
            if (!found && r[ID_W'(idx)]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
        return {found, sel};
    endfunction

    logic [ID_W-1:0] rot_ptr;
    logic [ID_W:0]   pick_cur;
    logic [ID_W:0]   pick_rot;
    logic            abort;
    logic            last_beat;
    logic            keep_client;

    assign rot_ptr   = (grant_id_reg == ID_W'(NUM_CLIENTS - 1)) ? '0
                                                                : grant_id_reg + ID_W'(1);
    assign pick_cur  = pick_from(req, rr_ptr_reg);
    assign pick_rot  = pick_from(req, rot_ptr);
    assign abort     = !req[grant_id_reg];
    assign last_beat = beat_done && (beat_cnt_reg == LEN_W'(1));

    // Back-to-back re-grant only on a clean completion with credit left.
    assign keep_client = !abort &&
        (({1'b0, used_cnt[grant_id_reg]} + (WEIGHT_W + 1)'(1)) <
         {1'b0, weight_eff[grant_id_reg]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            beat_cnt_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            grant_id_reg <= grant_id_next;
            beat_cnt_reg <= beat_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        grant_id_next = grant_id_reg;
        beat_cnt_next = beat_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        credit_inc    = 1'b0;
        credit_clr    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_cur[ID_W]) begin
                    state_next    = BURST;
                    grant_id_next = pick_cur[ID_W-1:0];
                    grant_next    = NUM_CLIENTS'(1) << pick_cur[ID_W-1:0];
                    beat_cnt_next = len_eff[pick_cur[ID_W-1:0]];
                end
            end
            BURST: begin
                if (abort || last_beat) begin
                    if (keep_client) begin
                        credit_inc    = 1'b1;
                        beat_cnt_next = len_eff[grant_id_reg];
                    end else begin
                        credit_clr  = 1'b1;
                        rr_ptr_next = rot_ptr;
                        if (pick_rot[ID_W]) begin
                            grant_id_next = pick_rot[ID_W-1:0];
                            grant_next    = NUM_CLIENTS'(1) << pick_rot[ID_W-1:0];
                            beat_cnt_next = len_eff[pick_rot[ID_W-1:0]];
                        end else begin
                            state_next    = IDLE;
                            grant_next    = '0;
                            beat_cnt_next = '0;
                        end
                    end
                end else if (beat_done) begin
                    beat_cnt_next = beat_cnt_reg - LEN_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Only the current winner's credit ever moves.
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_credit
            logic [WEIGHT_W-1:0] used_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    used_reg <= '0;
                end else if (state_reg == BURST && grant_id_reg == ID_W'(gi)) begin
                    if (credit_clr) begin
                        used_reg <= '0;
                    end else if (credit_inc) begin
                        used_reg <= used_reg + WEIGHT_W'(1);
                    end
                end
            end
            assign used_cnt[gi] = used_reg;
        end
    endgenerate

    assign grant      = grant_reg;
    assign grant_id   = grant_id_reg;
    assign busy       = (state_reg == BURST);
    assign burst_last = (state_reg == BURST) && last_beat;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb_wrr_burst_arbiter
//   Randomised stimulus against a burst/credit reference model, plus a few
//   directed scenarios (round-robin order, mid-burst reset, zero len/weight).
module tb_wrr_burst_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int WW = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic [N*WW-1:0] weight;
    logic            beat_done;
    logic [N-1:0]    grant;
    logic [1:0]      grant_id;
    logic            busy;
    logic            burst_last;

    wrr_burst_arbiter #(
        .NUM_CLIENTS (N),
        .LEN_W       (LW),
        .WEIGHT_W    (WW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_len    (req_len),
        .weight     (weight),
        .beat_done  (beat_done),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy),
        .burst_last (burst_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_busy;
    int m_gid;
    int m_left;      // beats remaining in current burst
    int m_ptr;
    int m_credit [N];

    function automatic int weff(int i);
        int w;
        w = int'(weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int leff(int i);
        int l;
        l = int'(req_len[i*LW +: LW]);
        return (l == 0) ? 1 : l;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_gid  = 0;
        m_left = 0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) m_credit[i] = weff(i);
    endtask

    // Start a burst for the first requester from m_ptr; go idle if none.
    task automatic model_choose();
        m_busy = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req[c]) begin
                m_busy = 1;
                m_gid  = c;
                m_left = leff(c);
                $display("burst start: client %0d len %0d credit %0d", c, m_left, m_credit[c]);
                break;
            end
        end
    endtask

    task automatic model_step();
        if (!m_busy) begin
            model_choose();
        end else begin
            bit ab;
            bit done;
            ab   = !req[m_gid];
            done = beat_done && (m_left == 1);
            if (ab || done) begin
                m_credit[m_gid]--;
                if (!ab && m_credit[m_gid] > 0) begin
                    m_left = leff(m_gid);
                    $display("burst again: client %0d len %0d credit %0d", m_gid, m_left, m_credit[m_gid]);
                end else begin
                    m_credit[m_gid] = weff(m_gid);
                    m_ptr = (m_gid + 1) % N;
                    model_choose();
                end
            end else if (beat_done) begin
                m_left--;
            end
        end
    endtask

    // Apply inputs at a negedge, check the combinational output, advance
    // the model across the posedge and check the registered outputs.
    task automatic do_cycle(input logic [N-1:0] r, input logic [N*LW-1:0] l, input logic bd);
        req       = r;
        req_len   = l;
        beat_done = bd;
        #1;
        check_val("burst_last", int'(burst_last), int'(m_busy && bd && m_left == 1));
        model_step();
        @(negedge clk);
        check_val("grant", int'(grant), m_busy ? (1 << m_gid) : 0);
        check_val("busy", int'(busy), int'(m_busy));
        if (m_busy) check_val("grant_id", int'(grant_id), m_gid);
    endtask

    task automatic apply_reset(input logic [N*WW-1:0] w);
        rst_n     = 1'b0;
        weight    = w;
        req       = '0;
        req_len   = '0;
        beat_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        check_val("rst_grant", int'(grant), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_grant_id", int'(grant_id), 0);
    endtask

    int rr_tbl [5] = '{1, 2, 4, 8, 1};

    initial begin
        logic [N-1:0]    r;
        logic [N*LW-1:0] l;
        logic [N*WW-1:0] w;

        rst_n = 1'b0;
        req = '0; req_len = '0; weight = '0; beat_done = 1'b0;

        // Plain round-robin: weights 1, len 1, beat every cycle.
        apply_reset({3'd1, 3'd1, 3'd1, 3'd1});
        for (int k = 0; k < 5; k++) begin
            do_cycle(4'b1111, {4'd1, 4'd1, 4'd1, 4'd1}, 1'b1);
            check_val("rr_seq", int'(grant), rr_tbl[k]);
        end

        // Weight 0 and len 0 on client 1: one beat, one burst.
        apply_reset({3'd1, 3'd1, 3'd0, 3'd1});
        do_cycle(4'b0010, 16'h0000, 1'b0);
        check_val("zero_len_grant", int'(grant), 2);
        do_cycle(4'b0010, 16'h0000, 1'b1);
        do_cycle(4'b0000, 16'h0000, 1'b0);
        check_val("zero_len_release", int'(grant), 0);

        // Mid-burst asynchronous reset with two beats left.
        apply_reset({3'd2, 3'd2, 3'd2, 3'd2});
        do_cycle(4'b0010, 16'h0030, 1'b0);
        do_cycle(4'b0010, 16'h0030, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_grant", int'(grant), 0);
        check_val("async_rst_busy", int'(busy), 0);
        check_val("async_rst_gid", int'(grant_id), 0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        do_cycle(4'b1111, 16'h1111, 1'b0);
        check_val("restart_client0", int'(grant), 1);

        // Randomised phases, fresh weights per phase (held through reset).
        for (int ph = 0; ph < 8; ph++) begin
            int dens;
            w = '0;
            for (int i = 0; i < N; i++) w[i*WW +: WW] = WW'($urandom_range(0, 4));
            apply_reset(w);
            dens = $urandom_range(6, 20);
            r = N'($urandom);
            for (int c = 0; c < 400; c++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, dens) == 0) r[i] = ~r[i];
                end
                l = '0;
                for (int i = 0; i < N; i++) l[i*LW +: LW] = LW'($urandom_range(0, 4));
                do_cycle(r, l, $urandom_range(0, 2) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one burst-oriented resource port among NUM_CLIENTS requesters.
- Each grant is held for a whole burst of req_len beats; a beat is counted on each resource beat_done pulse.
- A client may win up to weight consecutive bursts before priority rotates.
- Sits between the request/grant client vector and the shared resource. It is the burst-aware successor of the single-cycle req/grant arbiter.

Parameters:
- NUM_CLIENTS, 4, number of requesters (>=2)
- LEN_W, 4, width of per-client burst length field
- WEIGHT_W, 3, width of per-client weight field

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NUM_CLIENTS  level request per client
- req_len  input  NUM_CLIENTS*LEN_W  beats per burst, client i at [i*LEN_W +: LEN_W]; sampled at grant decision
- weight  input  NUM_CLIENTS*WEIGHT_W  consecutive-burst allowance per client; quasi-static
- beat_done  input  1  resource completed one beat of the current burst
- grant  output  NUM_CLIENTS  registered one-hot grant, or zero
- grant_id  output  $clog2(NUM_CLIENTS)  index of the granted client; valid while busy
- busy  output  1  a burst is in progress (grant != 0)
- burst_last  output  1  combinational; high when beat_done completes the final beat of the burst

Behaviour:
- Reset values: grant=0, grant_id=0, busy=0, rr pointer=0, beat counter=0. Each credit counter is loaded with its weight; a weight of 0 is treated as 1.
- FSM states:
  - IDLE (grant=0)
  - BURST (grant held)
- Selection function (combinational): first i with req[i]=1, scanning from the rr pointer upward with modulo-NUM_CLIENTS wrap. Any selection is one-hot.
- IDLE -> BURST:
  - When any req=1, the winner's grant is registered. Latency is exactly 1 cycle from req high to grant high.
  - The beat counter loads the winner's req_len; a length of 0 is treated as 1.
- In BURST:
  - grant, grant_id and the beat counter are stable except on beat_done.
  - Each beat_done decrements the beat counter.
  - beat_done is ignored in IDLE.
- Burst end occurs when beat_done arrives with counter==1 (burst_last=1), or when req[grant_id] drops mid-burst (abort). On abort:
  - grant falls the next cycle.
  - A beat_done in the same cycle still counts as burst end.
- Credit update at burst end:
  - The winner's credit decrements.
  - If the resulting credit >0 and req[grant_id] is still 1 (completion case only), the same client is re-granted back-to-back. No gap; the beat counter reloads from current req_len; the rr pointer is unchanged.
  - Otherwise the winner's credit reloads to its weight and the rr pointer becomes grant_id+1 (mod NUM_CLIENTS).
  - Selection then runs with the new pointer. If a winner exists, its grant is registered for the next cycle (zero-bubble handover); if not, the FSM returns to IDLE.
- Abort always rotates the pointer and reloads the aborting client's credit.
- Credits of non-winning clients never change. Reloads use the current weight value.
- Fairness: every continuously requesting client is granted within (NUM_CLIENTS-1)*max_weight bursts.
- Asynchronous reset mid-burst: grant drops immediately and all state returns to reset values.

Test Plan:
- Single client: req=4'b0010, req_len[1]=3, weight=1. Grant=0010 one cycle after req; three beat_done pulses; burst_last on the third; grant=0 the following cycle if req drops, otherwise 0010 is re-granted after rotation finds only client 1.
- All request, weights {1,1,1,1}, len 1, beat_done every cycle: grant sequence is 0001, 0010, 0100, 1000, 0001 with no idle cycles between grants.
- Weights {3,1,1,1}, all request, len 2: client 0 gets 3 consecutive bursts (6 beats), then client 1 gets 1 burst, then client 2, then client 3, then client 0 again for 3 bursts.
- Abort: client 2 granted with len 5; req[2] drops after 2 beats. grant=0 next cycle, or the next requester (client 3 first) if pending; the pointer moves to 3.
- len=0 and weight=0 on client 1: treated as 1 beat and 1 burst; grant releases after a single beat_done.
- Reset asserted mid-burst with counter=2: grant, busy and grant_id go to 0 immediately. After release, arbitration restarts from client 0.
